// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a runtime-programmable pattern, length and
// overlap mode. It produces a registered detect pulse and a saturating match count.
module seq_detector_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 'b1001,
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b1,
  localparam int                LEN_W       = $clog2(MAX_LEN+1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clear,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               data_valid,
  input  logic               data,
  output logic               detect,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Length 0 would match every bit, so it is forced up to 1.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0)          return LEN_W'(1);
    else if (l > LEN_MAX) return LEN_MAX;
    else                  return l;
  endfunction

  logic [MAX_LEN-1:0] pattern_q, hist_q, hist_nxt, mask;
  logic [LEN_W-1:0]   len_q, fill_q, fill_inc;
  logic               overlap_q;
  logic               accept, eligible, match;

  // The window compares only the low len bits of the candidate.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
    assign mask[i] = (LEN_W'(i) < len_q);
  end

  assign accept   = data_valid && !clear && !cfg_we;
  assign hist_nxt = {hist_q[MAX_LEN-2:0], data};
  assign eligible = ({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q};
  assign match    = accept && eligible && (((hist_nxt ^ pattern_q) & mask) == '0);
  assign fill_inc = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= clamp_len(LEN_W'(DEF_LEN));
      overlap_q <= DEF_OVERLAP;
    end else if (!clear && cfg_we) begin
      pattern_q <= cfg_pattern;
      len_q     <= clamp_len(cfg_len);
      overlap_q <= cfg_overlap;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_q      <= '0;
      fill_q      <= '0;
      detect      <= 1'b0;
      match_count <= '0;
    end else begin
      detect <= match;
      if (clear) begin
        fill_q      <= '0;
        match_count <= '0;
      end else if (cfg_we) begin
        fill_q <= '0;
      end else if (data_valid) begin
        hist_q <= hist_nxt;
        // Non-overlapping mode drops the matched bits from eligibility.
        fill_q <= (match && !overlap_q) ? '0 : fill_inc;
        if (match && match_count != CNT_MAX)
          match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed scoreboard bench for seq_detector_param (MAX_LEN=8, CNT_W=4).
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clear = 1'b0, cfg_we = 1'b0, cfg_overlap = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       data_valid = 1'b0, data = 1'b0;
  logic       detect;
  logic [3:0] match_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       det;
    logic [3:0] cnt;
    string      tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_detector_param #(.MAX_LEN(8), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .data_valid(data_valid), .data(data),
    .detect(detect), .match_count(match_count)
  );

  // Monitor: every driven edge has exactly one expected response, checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (detect !== e.det || match_count !== e.cnt) begin
        n_fail++;
        $display("FAIL %s: got detect=%0b count=%0d, want detect=%0b count=%0d",
                 e.tag, detect, match_count, e.det, e.cnt);
      end
    end
  end

  task automatic drive(input logic c, we, v, d, input logic [7:0] pat,
                       input logic [3:0] ln, input logic ov,
                       input logic edet, input logic [3:0] ecnt, input string tag);
    @(negedge clk); #1;
    clear = c; cfg_we = we; data_valid = v; data = d;
    cfg_pattern = pat; cfg_len = ln; cfg_overlap = ov;
    sb.push_back('{edet, ecnt, tag});
  endtask

  task automatic bit_in(input logic d, input logic edet, input logic [3:0] ecnt, input string tag);
    drive(1'b0, 1'b0, 1'b1, d, 8'h00, 4'd0, 1'b0, edet, ecnt, tag);
  endtask

  task automatic idle(input logic [3:0] ecnt, input string tag);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, ecnt, tag);
  endtask

  task automatic do_clear(input string tag);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 4'd1, 1'b0, 1'b0, 4'd0, tag);
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] ln, input logic ov,
                     input logic [3:0] ecnt, input string tag);
    drive(1'b0, 1'b1, 1'b0, 1'b0, pat, ln, ov, 1'b0, ecnt, tag);
  endtask

  initial begin
    logic [7:0] a5;
    int m;
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    idle(4'd0, "reset_state");

    // Default 1001 overlapping
    bit_in(1, 0, 0, "def_b1"); bit_in(0, 0, 0, "def_b2"); bit_in(0, 0, 0, "def_b3");
    bit_in(1, 1, 1, "def_b4"); bit_in(0, 0, 1, "def_b5"); bit_in(0, 0, 1, "def_b6");
    bit_in(1, 1, 2, "def_b7"); idle(4'd2, "def_idle");

    // 11, non-overlapping then overlapping
    do_clear("clr1");
    cfg(8'h03, 4'd2, 1'b0, 4'd0, "cfg_11_novl");
    bit_in(1, 0, 0, "novl_b1"); bit_in(1, 1, 1, "novl_b2");
    bit_in(1, 0, 1, "novl_b3"); bit_in(1, 1, 2, "novl_b4");
    cfg(8'h03, 4'd2, 1'b1, 4'd2, "cfg_11_ovl");
    do_clear("clr2");
    bit_in(1, 0, 0, "ovl_b1"); bit_in(1, 1, 1, "ovl_b2");
    bit_in(1, 1, 2, "ovl_b3"); bit_in(1, 1, 3, "ovl_b4");

    // Valid gaps between bits
    cfg(8'h09, 4'd4, 1'b1, 4'd3, "cfg_1001");
    do_clear("clr3");
    bit_in(1, 0, 0, "gap_b1"); repeat (3) idle(4'd0, "gap1");
    bit_in(0, 0, 0, "gap_b2"); repeat (3) idle(4'd0, "gap2");
    bit_in(0, 0, 0, "gap_b3"); repeat (3) idle(4'd0, "gap3");
    bit_in(1, 1, 1, "gap_b4"); repeat (3) idle(4'd1, "gap4");

    // Async reset mid-pattern
    bit_in(1, 0, 1, "rst_b1"); bit_in(0, 0, 1, "rst_b2"); bit_in(0, 0, 1, "rst_b3");
    @(negedge clk); #1;
    data_valid = 1'b0; cfg_we = 1'b0; clear = 1'b0;
    rstn = 1'b0; #2;
    n_tests++;
    if (detect !== 1'b0 || match_count !== 4'd0) begin
      n_fail++;
      $display("FAIL async_rst: got detect=%0b count=%0d, want detect=0 count=0", detect, match_count);
    end
    #1 rstn = 1'b1;
    bit_in(1, 0, 0, "rst_b4");

    // cfg_we on the edge of the final pattern bit
    do_clear("clr4");
    bit_in(1, 0, 0, "cw_b1"); bit_in(0, 0, 0, "cw_b2"); bit_in(0, 0, 0, "cw_b3");
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h09, 4'd4, 1'b1, 1'b0, 4'd0, "cw_b4_cfg");
    bit_in(1, 0, 0, "cw_r1"); bit_in(0, 0, 0, "cw_r2");
    bit_in(0, 0, 0, "cw_r3"); bit_in(1, 1, 1, "cw_r4");

    // cfg_len=0 clamps to 1, then a continuous run of ones
    cfg(8'h01, 4'd0, 1'b1, 4'd1, "cfg_len0");
    bit_in(1, 1, 2, "l0_b1"); bit_in(0, 0, 2, "l0_b2"); bit_in(1, 1, 3, "l0_b3");
    bit_in(1, 1, 4, "run_b1"); bit_in(1, 1, 5, "run_b2"); bit_in(1, 1, 6, "run_b3");
    bit_in(0, 0, 6, "run_b4");

    // cfg_len=15 clamps to 8; A5 x20 saturates the 4-bit counter
    cfg(8'hA5, 4'd15, 1'b1, 4'd6, "cfg_a5");
    do_clear("clr5");
    a5 = 8'hA5;
    m = 0;
    for (int r = 0; r < 20; r++) begin
      for (int b = 7; b >= 0; b--) begin
        if (b == 0) m++;
        bit_in(a5[b], (b == 0), (m > 15) ? 4'd15 : 4'(m), $sformatf("a5_r%0d_b%0d", r, b));
      end
    end
    idle(4'd15, "sat_idle");
    do_clear("clr6");
    idle(4'd0, "final");

    // Drain bound
    repeat (4) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
